// File: rtl/des_avalanche_ctrl.sv
// rtl/des_avalanche_ctrl.sv - drives the des core through a reference run plus one run per flipped input bit
// and reports the Hamming distance of each result from the reference ciphertext.
module des_avalanche_ctrl #(
    parameter int NBITS      = 64,
    parameter int RST_CYCLES = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [NBITS-1:0] base_i,
    input  logic [NBITS-1:0] key_i,
    output logic             des_rst_n_o,
    output logic             des_enable_o,
    output logic             des_mode_o,
    output logic [NBITS-1:0] des_data_o,
    output logic [NBITS-1:0] des_key_o,
    input  logic [NBITS-1:0] des_data_i,
    input  logic             des_ready_i,
    output logic             busy_o,
    output logic [NBITS-1:0] ref_ct_o,
    output logic             res_valid_o,
    output logic [5:0]       bit_idx_o,
    output logic [6:0]       hd_o,
    output logic [12:0]      total_o,
    output logic [6:0]       min_o,
    output logic [6:0]       max_o,
    output logic             done_o,
    output logic             err_o
);
    typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_CAPREF, S_ACC, S_DONE} state_t;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t           state_q;
    logic [NBITS-1:0] base_q, key_q, data_q, cap_q, ref_ct_q;
    logic             mode_q, flip_phase_q, des_rst_n_q, des_enable_q;
    logic [5:0]       idx_q, bit_idx_q;
    logic [TW-1:0]    timer_q;
    logic [RW-1:0]    rst_cnt_q;
    logic [6:0]       hd_q, min_q, max_q;
    logic [12:0]      total_q;
    logic             busy_q, res_valid_q, done_q, err_q;

    logic [NBITS-1:0] diff_d;
    logic [6:0]       hd_d;

    always_comb begin
        diff_d = cap_q ^ ref_ct_q;
        hd_d   = '0;
        for (int i = 0; i < NBITS; i++) begin
            hd_d = hd_d + 7'(diff_d[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            key_q        <= '0;
            data_q       <= '0;
            cap_q        <= '0;
            ref_ct_q     <= '0;
            mode_q       <= 1'b1;
            flip_phase_q <= 1'b0;
            des_rst_n_q  <= 1'b0;
            des_enable_q <= 1'b0;
            idx_q        <= '0;
            bit_idx_q    <= '0;
            timer_q      <= '0;
            rst_cnt_q    <= '0;
            hd_q         <= '0;
            min_q        <= 7'd127;
            max_q        <= '0;
            total_q      <= '0;
            busy_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        base_q       <= base_i;
                        key_q        <= key_i;
                        mode_q       <= mode_i;
                        data_q       <= base_i;
                        total_q      <= '0;
                        max_q        <= '0;
                        min_q        <= 7'd127;
                        err_q        <= 1'b0;
                        idx_q        <= '0;
                        flip_phase_q <= 1'b0;
                        rst_cnt_q    <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= S_RST;
                    end
                end
                S_RST: begin
                    if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
                        des_rst_n_q  <= 1'b1;
                        des_enable_q <= 1'b1;
                        timer_q      <= '0;
                        state_q      <= S_RUN;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    // Ready in the first run cycle may be left over from the previous run.
                    if (des_ready_i && timer_q != '0) begin
                        cap_q        <= des_data_i;
                        des_rst_n_q  <= 1'b0;
                        des_enable_q <= 1'b0;
                        state_q      <= flip_phase_q ? S_ACC : S_CAPREF;
                    end else if (timer_q == TW'(TIMEOUT)) begin
                        err_q        <= 1'b1;
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        des_rst_n_q  <= 1'b0;
                        des_enable_q <= 1'b0;
                        state_q      <= S_DONE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_CAPREF: begin
                    ref_ct_q     <= cap_q;
                    flip_phase_q <= 1'b1;
                    data_q       <= base_q ^ {{(NBITS-1){1'b0}}, 1'b1};
                    rst_cnt_q    <= '0;
                    state_q      <= S_RST;
                end
                S_ACC: begin
                    res_valid_q <= 1'b1;
                    bit_idx_q   <= idx_q;
                    hd_q        <= hd_d;
                    total_q     <= total_q + 13'(hd_d);
                    if (hd_d < min_q) min_q <= hd_d;
                    if (hd_d > max_q) max_q <= hd_d;
                    if (idx_q == 6'(NBITS - 1)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        idx_q     <= idx_q + 1'b1;
                        data_q    <= base_q ^ ({{(NBITS-1){1'b0}}, 1'b1} << (idx_q + 6'd1));
                        rst_cnt_q <= '0;
                        state_q   <= S_RST;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign des_rst_n_o  = des_rst_n_q;
    assign des_enable_o = des_enable_q;
    assign des_mode_o   = mode_q;
    assign des_data_o   = data_q;
    assign des_key_o    = key_q;
    assign busy_o       = busy_q;
    assign ref_ct_o     = ref_ct_q;
    assign res_valid_o  = res_valid_q;
    assign bit_idx_o    = bit_idx_q;
    assign hd_o         = hd_q;
    assign total_o      = total_q;
    assign min_o        = min_q;
    assign max_o        = max_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule
